// File: rtl/memory_bus_master.sv
// memory_bus_master: single-transfer initiator for the main-memory RD/WR/ACK bus.
// Active-low strobes, ACK timeout, 4-phase release before the next request is taken.
`default_nettype none

module memory_bus_master #(
  parameter int DATAWIDTH_BUS  = 32,
  parameter int TIMEOUT_CYCLES = 16,
  parameter int TIMEOUT_WIDTH  = 5
) (
  input  logic                     MEM_MASTER_CLOCK_50,
  input  logic                     MEM_MASTER_RESET_InLow,
  input  logic                     MEM_MASTER_REQ_In,
  input  logic                     MEM_MASTER_WE_In,
  input  logic [DATAWIDTH_BUS-1:0] MEM_MASTER_ADDR_InBUS,
  input  logic [DATAWIDTH_BUS-1:0] MEM_MASTER_WDATA_InBUS,
  output logic [DATAWIDTH_BUS-1:0] MEM_MASTER_RDATA_OutBUS,
  output logic                     MEM_MASTER_DONE_Out,
  output logic                     MEM_MASTER_ERR_Out,
  output logic                     MEM_MASTER_BUSY_Out,
  output logic [DATAWIDTH_BUS-1:0] MEM_MASTER_ADDRESS_OutBUS,
  output logic [DATAWIDTH_BUS-1:0] MEM_MASTER_DATA_OutBUS,
  output logic                     MEM_MASTER_RD_Out,
  output logic                     MEM_MASTER_WR_Out,
  input  logic [DATAWIDTH_BUS-1:0] MEM_MASTER_DATA_InBUS,
  input  logic                     MEM_MASTER_ACK_In
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_READ    = 3'd1,
    S_WRITE   = 3'd2,
    S_ERROR   = 3'd3,
    S_RELEASE = 3'd4
  } state_t;

  localparam logic [TIMEOUT_WIDTH-1:0] TIMER_LAST = TIMEOUT_WIDTH'(TIMEOUT_CYCLES - 1);

  state_t                     state, state_nxt;
  logic [TIMEOUT_WIDTH-1:0]   timer, timer_nxt;
  logic [DATAWIDTH_BUS-1:0]   rdata, rdata_nxt;
  logic [DATAWIDTH_BUS-1:0]   address, address_nxt;
  logic [DATAWIDTH_BUS-1:0]   data_out, data_out_nxt;
  logic                       rd_n, rd_n_nxt;
  logic                       wr_n, wr_n_nxt;
  logic                       done, done_nxt;
  logic                       err, err_nxt;
  logic                       busy_nxt, busy;

  always_ff @(posedge MEM_MASTER_CLOCK_50 or negedge MEM_MASTER_RESET_InLow) begin
    if (!MEM_MASTER_RESET_InLow) begin
      state    <= S_IDLE;
      timer    <= '0;
      rdata    <= '0;
      address  <= '0;
      data_out <= '0;
      rd_n     <= 1'b1;
      wr_n     <= 1'b1;
      done     <= 1'b0;
      err      <= 1'b0;
      busy     <= 1'b0;
    end else begin
      state    <= state_nxt;
      timer    <= timer_nxt;
      rdata    <= rdata_nxt;
      address  <= address_nxt;
      data_out <= data_out_nxt;
      rd_n     <= rd_n_nxt;
      wr_n     <= wr_n_nxt;
      done     <= done_nxt;
      err      <= err_nxt;
      busy     <= busy_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    timer_nxt    = timer;
    rdata_nxt    = rdata;
    address_nxt  = address;
    data_out_nxt = data_out;
    rd_n_nxt     = rd_n;
    wr_n_nxt     = wr_n;
    done_nxt     = 1'b0;
    err_nxt      = 1'b0;
    case (state)
      S_IDLE: begin
        timer_nxt = '0;
        if (MEM_MASTER_REQ_In) begin
          address_nxt = MEM_MASTER_ADDR_InBUS;
          // Misaligned requests never reach the bus.
          if (MEM_MASTER_ADDR_InBUS[1:0] != 2'b00) begin
            state_nxt = S_ERROR;
            err_nxt   = 1'b1;
          end else if (MEM_MASTER_WE_In) begin
            state_nxt    = S_WRITE;
            wr_n_nxt     = 1'b0;
            data_out_nxt = MEM_MASTER_WDATA_InBUS;
          end else begin
            state_nxt = S_READ;
            rd_n_nxt  = 1'b0;
          end
        end
      end
      S_READ, S_WRITE: begin
        // ACK is checked first so it wins over a simultaneous timeout.
        if (MEM_MASTER_ACK_In) begin
          rd_n_nxt  = 1'b1;
          wr_n_nxt  = 1'b1;
          done_nxt  = 1'b1;
          state_nxt = S_RELEASE;
          if (state == S_READ) rdata_nxt = MEM_MASTER_DATA_InBUS;
        end else if (timer == TIMER_LAST) begin
          rd_n_nxt  = 1'b1;
          wr_n_nxt  = 1'b1;
          err_nxt   = 1'b1;
          state_nxt = S_ERROR;
        end else begin
          timer_nxt = timer + 1'b1;
        end
      end
      S_ERROR: begin
        state_nxt = S_RELEASE;
      end
      S_RELEASE: begin
        if (!MEM_MASTER_ACK_In) begin
          state_nxt = S_IDLE;
          timer_nxt = '0;
        end
      end
      default: begin
        state_nxt = S_IDLE;
        rd_n_nxt  = 1'b1;
        wr_n_nxt  = 1'b1;
      end
    endcase
    busy_nxt = (state_nxt != S_IDLE);
  end

  assign MEM_MASTER_RDATA_OutBUS   = rdata;
  assign MEM_MASTER_DONE_Out       = done;
  assign MEM_MASTER_ERR_Out        = err;
  assign MEM_MASTER_BUSY_Out       = busy;
  assign MEM_MASTER_ADDRESS_OutBUS = address;
  assign MEM_MASTER_DATA_OutBUS    = data_out;
  assign MEM_MASTER_RD_Out         = rd_n;
  assign MEM_MASTER_WR_Out         = wr_n;

endmodule

`default_nettype wire
